// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one spi_master between REQ_COUNT requesters.
// Serves one transaction at a time; a master that never goes busy yields err instead of done.
module spi_arbiter #(
    parameter int  REQ_COUNT       = 4,
    parameter int  SLAVE_ADDRS_LEN = 3,
    parameter int  START_TIMEOUT   = 15,
    localparam int GW              = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [REQ_COUNT-1:0]                 req,
    input  logic [REQ_COUNT*SLAVE_ADDRS_LEN-1:0] req_addr,
    input  logic [REQ_COUNT*32-1:0]              req_tx,
    input  logic [REQ_COUNT*2-1:0]               req_len,
    output logic [REQ_COUNT-1:0]                 ack,
    output logic [REQ_COUNT-1:0]                 done,
    output logic [REQ_COUNT-1:0]                 err,
    output logic [31:0]                          rx_data,
    output logic [GW-1:0]                        grant_id,
    output logic                                 mst_start,
    output logic [SLAVE_ADDRS_LEN-1:0]           mst_addr,
    output logic [31:0]                          mst_tx,
    output logic [1:0]                           mst_len,
    input  logic                                 mst_busy,
    input  logic [31:0]                          mst_rx
);

    localparam int              CW           = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TIMEOUT_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0]   LAST_REQ     = GW'(REQ_COUNT - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, COMPLETE} state_e;

    state_e                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [GW-1:0]                grant_q, grant_d;
    logic [GW-1:0]                last_q, last_d;
    logic [SLAVE_ADDRS_LEN-1:0]   addr_q, addr_d;
    logic [31:0]                  tx_q, tx_d;
    logic [1:0]                   len_q, len_d;
    logic [31:0]                  rx_q, rx_d;

    logic                         pick_valid;
    logic [GW-1:0]                pick_idx;
    logic                         timeout;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % REQ_COUNT;
        return GW'(s);
    endfunction

    // Scan from farthest to nearest so the requester right after last_q wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = REQ_COUNT; k >= 1; k--) begin
            if (req[rr_idx(last_q, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_idx(last_q, k);
            end
        end
    end

    assign timeout = (cnt_q == TIMEOUT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pick_valid) state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (mst_busy)     state_d = WAIT_DONE;
                else if (timeout) state_d = IDLE;
            end
            WAIT_DONE: if (!mst_busy) state_d = COMPLETE;
            COMPLETE:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        ack       = '0;
        done      = '0;
        err       = '0;
        mst_start = 1'b0;
        case (state_q)
            IDLE:      if (pick_valid) ack[pick_idx] = 1'b1;
            START:     mst_start = 1'b1;
            WAIT_BUSY: if (!mst_busy && timeout) err[grant_q] = 1'b1;
            COMPLETE:  done[grant_q] = 1'b1;
            default:   ;
        endcase
    end

    // rx is captured on the edge leaving WAIT_DONE so rx_data is already valid while done pulses.
    always_comb begin
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        len_d   = len_q;
        rx_d    = rx_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    addr_d  = req_addr[pick_idx*SLAVE_ADDRS_LEN +: SLAVE_ADDRS_LEN];
                    tx_d    = req_tx[pick_idx*32 +: 32];
                    len_d   = req_len[pick_idx*2 +: 2];
                end
            end
            START:     cnt_d = '0;
            WAIT_BUSY: if (!mst_busy) cnt_d = cnt_q + 1'b1;
            WAIT_DONE: if (!mst_busy) rx_d = mst_rx;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= LAST_REQ;
            addr_q  <= '0;
            tx_q    <= '0;
            len_q   <= '0;
            rx_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            len_q   <= len_d;
            rx_q    <= rx_d;
        end
    end

    assign rx_data  = rx_q;
    assign grant_id = grant_q;
    assign mst_addr = addr_q;
    assign mst_tx   = tx_q;
    assign mst_len  = len_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a small behavioral spi_master busy model.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_spi_arbiter;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = {3'd7, 3'd5, 3'd3, 3'd1};
    logic [N*32-1:0] req_tx   = {32'hDEAD_0003, 32'h0000_00A5, 32'hBEEF_0001, 32'hCAFE_0000};
    logic [N*2-1:0]  req_len  = {2'b11, 2'b00, 2'b10, 2'b01};
    logic [N-1:0]    ack, done, err;
    logic [31:0]     rx_data;
    logic [GW-1:0]   grant_id;
    logic            mst_start;
    logic [AW-1:0]   mst_addr;
    logic [31:0]     mst_tx;
    logic [1:0]      mst_len;
    logic            mst_busy = 1'b0;
    logic [31:0]     mst_rx = '0;

    int checks = 0;
    int errors = 0;

    spi_arbiter #(.REQ_COUNT(N), .SLAVE_ADDRS_LEN(AW), .START_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_tx(req_tx), .req_len(req_len),
        .ack(ack), .done(done), .err(err), .rx_data(rx_data), .grant_id(grant_id),
        .mst_start(mst_start), .mst_addr(mst_addr), .mst_tx(mst_tx), .mst_len(mst_len),
        .mst_busy(mst_busy), .mst_rx(mst_rx)
    );

    always #5 clk = ~clk;

    // spi_master model: busy rises busy_delay cycles after start and stays for busy_len cycles.
    int busy_delay = 3;
    int busy_len   = 20;
    bit never_busy = 1'b0;
    int since      = -1;

    always @(negedge clk) begin
        if (rst) begin
            since    = -1;
            mst_busy = 1'b0;
        end else begin
            if (mst_start) since = 0;
            else if (since >= 0 && since < 10000) since++;
            mst_busy = !never_busy && since >= busy_delay && since < busy_delay + busy_len;
        end
    end

    // Event log sampled at the active edge (values settled during the preceding cycle).
    int q_ack[$];
    int q_done[$];
    int q_err[$];
    logic [31:0] q_tx[$];
    int cyc = 0, start_cnt = 0, start_cyc = -1, fall_cyc = -1, done_cyc = -1, err_cyc = -1;
    int multi_viol = 0, alt_viol = 0;
    bit outstanding = 1'b0, prev_busy = 1'b0;

    function automatic int first_one(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            outstanding = 1'b0;
            prev_busy   = 1'b0;
        end else begin
            cyc++;
            if ($countones(ack) > 1 || $countones(done) > 1 || $countones(err) > 1) multi_viol++;
            if (done != 0 && err != 0) multi_viol++;
            if (ack != 0) begin
                if (outstanding) alt_viol++;
                outstanding = 1'b1;
                q_ack.push_back(first_one(ack));
            end
            if (done != 0 || err != 0) begin
                if (!outstanding) alt_viol++;
                outstanding = 1'b0;
            end
            if (done != 0) begin q_done.push_back(first_one(done)); done_cyc = cyc; end
            if (err != 0)  begin q_err.push_back(first_one(err));   err_cyc  = cyc; end
            if (mst_start) begin start_cnt++; start_cyc = cyc; q_tx.push_back(mst_tx); end
            if (prev_busy && !mst_busy) fall_cyc = cyc;
            prev_busy = mst_busy;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        q_ack.delete(); q_done.delete(); q_err.delete(); q_tx.delete();
        start_cnt = 0; start_cyc = -1; fall_cyc = -1; done_cyc = -1; err_cyc = -1;
        multi_viol = 0; alt_viol = 0;
    endtask

    // what: 0 = end of transaction (done or err), 1 = mst_busy high
    task automatic wait_for(input int what, input int max_cyc, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < max_cyc && !hit; i++) begin
            step();
            hit = (what == 0) ? (done != 0 || err != 0) : mst_busy;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL %s: event not seen within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0;
        step(); step();
        checks++; if (ack !== 4'b0 || done !== 4'b0 || err !== 4'b0) begin errors++; $display("FAIL reset_pulses: ack=%b done=%b err=%b expected 0", ack, done, err); end
        checks++; if (mst_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", mst_start); end
        checks++; if (mst_addr !== 3'd0 || mst_tx !== 32'h0 || mst_len !== 2'd0) begin errors++; $display("FAIL reset_mst: addr=%0d tx=%h len=%0d expected 0", mst_addr, mst_tx, mst_len); end
        checks++; if (rx_data !== 32'h0 || grant_id !== 2'd0) begin errors++; $display("FAIL reset_rx_grant: rx=%h grant=%0d expected 0", rx_data, grant_id); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        clear_logs();
        never_busy = 1'b0; busy_delay = 3; busy_len = 20; mst_rx = 32'h0000_005A;
        req = 4'b0100;
        #1;
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", ack); end
        step();
        req = '0;
        checks++; if (mst_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", mst_start); end
        checks++; if (mst_addr !== 3'd5 || mst_tx !== 32'hA5 || mst_len !== 2'b00) begin errors++; $display("FAIL single_fields: addr=%0d tx=%h len=%0d expected 5 a5 0", mst_addr, mst_tx, mst_len); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", grant_id); end
        wait_for(0, 100, "single_wait_done");
        checks++; if (done !== 4'b0100 || err !== 4'b0) begin errors++; $display("FAIL single_done: done=%b err=%b expected 0100 0000", done, err); end
        checks++; if (rx_data !== 32'h5A) begin errors++; $display("FAIL single_rx: got %h expected 5a", rx_data); end
        step();
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL single_done_pulse: got %b expected 0", done); end
        checks++; if (done_cyc != fall_cyc + 1) begin errors++; $display("FAIL single_latency: done at %0d, busy fall at %0d, expected 1 cycle apart", done_cyc, fall_cyc); end
        checks++; if (start_cnt != 1 || q_err.size() != 0) begin errors++; $display("FAIL single_counts: starts=%0d errs=%0d expected 1 0", start_cnt, q_err.size()); end
    endtask

    task automatic test_timeout();
        clear_logs();
        never_busy = 1'b1;
        req = 4'b0010;
        #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL timeout_ack: got %b expected 0010", ack); end
        step();
        req = '0;
        wait_for(0, 40, "timeout_wait_err");
        checks++; if (err !== 4'b0010 || done !== 4'b0) begin errors++; $display("FAIL timeout_err: err=%b done=%b expected 0010 0000", err, done); end
        checks++; if (rx_data !== 32'h5A) begin errors++; $display("FAIL timeout_rx: got %h expected 5a", rx_data); end
        step();
        checks++; if (err_cyc - start_cyc != 15) begin errors++; $display("FAIL timeout_cycles: got %0d expected 15", err_cyc - start_cyc); end
        checks++; if (q_done.size() != 0 || err !== 4'b0) begin errors++; $display("FAIL timeout_no_done: dones=%0d err=%b expected 0 0000", q_done.size(), err); end
        never_busy = 1'b0;
    endtask

    task automatic test_wrap();
        clear_logs();
        busy_delay = 3; busy_len = 8; mst_rx = 32'hC3C3_0003;
        req = 4'b1000;
        #1;
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL wrap_ack3: got %b expected 1000", ack); end
        step();
        req = '0;
        wait_for(1, 20, "wrap_wait_busy");
        step();
        req = 4'b0001;
        #1;
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL wrap_ack_busy: got %b expected 0000", ack); end
        wait_for(0, 40, "wrap_wait_done3");
        checks++; if (done !== 4'b1000 || rx_data !== 32'hC3C3_0003) begin errors++; $display("FAIL wrap_done3: done=%b rx=%h expected 1000 c3c30003", done, rx_data); end
        mst_rx = 32'h0000_00F0;
        step();
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wrap_ack0: got %b expected 0001", ack); end
        step();
        req = '0;
        checks++; if (grant_id !== 2'd0 || mst_addr !== 3'd1 || mst_tx !== 32'hCAFE_0000 || mst_len !== 2'b01) begin errors++; $display("FAIL wrap_fields0: grant=%0d addr=%0d tx=%h len=%0d expected 0 1 cafe0000 1", grant_id, mst_addr, mst_tx, mst_len); end
        wait_for(0, 40, "wrap_wait_done0");
        checks++; if (done !== 4'b0001 || rx_data !== 32'hF0) begin errors++; $display("FAIL wrap_done0: done=%b rx=%h expected 0001 f0", done, rx_data); end
        step();
    endtask

    task automatic test_reset_mid();
        clear_logs();
        busy_delay = 3; busy_len = 20; mst_rx = 32'h1234_5678;
        req = 4'b0010;
        #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL rstmid_ack: got %b expected 0010", ack); end
        step();
        req = '0;
        wait_for(1, 20, "rstmid_wait_busy");
        step();
        rst = 1'b1;
        #1;
        checks++; if (ack !== 4'b0 || done !== 4'b0 || err !== 4'b0 || mst_start !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: ack=%b done=%b err=%b start=%b expected 0", ack, done, err, mst_start); end
        checks++; if (mst_addr !== 3'd0 || mst_tx !== 32'h0 || rx_data !== 32'h0 || grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_regs: addr=%0d tx=%h rx=%h grant=%0d expected 0", mst_addr, mst_tx, rx_data, grant_id); end
        step(); step(); step();
        rst = 1'b0;
        checks++; if (q_done.size() != 0 || q_err.size() != 0) begin errors++; $display("FAIL rstmid_abandon: dones=%0d errs=%0d expected 0 0", q_done.size(), q_err.size()); end
        req = 4'b0010;
        #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL rstmid_reack: got %b expected 0010", ack); end
        step();
        req = '0;
        wait_for(0, 60, "rstmid_wait_done");
        checks++; if (done !== 4'b0010 || rx_data !== 32'h1234_5678) begin errors++; $display("FAIL rstmid_done: done=%b rx=%h expected 0010 12345678", done, rx_data); end
        step();
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        req = 4'b1111;
        busy_delay = 2; busy_len = 4; mst_rx = 32'h0BAD_F00D;
        clear_logs();
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 300 && q_done.size() < 5; i++) step();
        req = '0;
        if (q_done.size() < 5) begin
            checks++; errors++;
            $display("FAIL rr_timeout: only %0d transactions completed, expected 5", q_done.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= q_ack.size() || i >= q_done.size()) begin
                errors++; $display("FAIL rr_order[%0d]: missing event, expected requester %0d", i, i % 4);
            end else if (q_ack[i] != i % 4 || q_done[i] != i % 4) begin
                errors++; $display("FAIL rr_order[%0d]: ack=%0d done=%0d expected %0d", i, q_ack[i], q_done[i], i % 4);
            end
        end
        checks++; if (alt_viol != 0 || multi_viol != 0) begin errors++; $display("FAIL rr_exclusive: alternation=%0d multibit=%0d expected 0 0", alt_viol, multi_viol); end
        checks++;
        if (q_tx.size() < 4) begin errors++; $display("FAIL rr_tx: %0d starts seen, expected at least 4", q_tx.size()); end
        else if (q_tx[1] !== 32'hBEEF_0001 || q_tx[3] !== 32'hDEAD_0003) begin errors++; $display("FAIL rr_tx: got %h %h expected beef0001 dead0003", q_tx[1], q_tx[3]); end
        checks++; if (rx_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL rr_rx: got %h expected 0badf00d", rx_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_round_robin();
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
